// File: rtl/pipe_hazard_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard controller for a five-stage in-order pipeline.
//               Detects load-use and RAW hazards, selects EX operand
//               forwarding, inserts branch bubbles and freezes the pipe
//               while the data memory is busy (with a sticky timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int RA_W         = 5,
    parameter int BR_STALL_CYC = 2,
    parameter int FWD_EN       = 1,
    parameter int MEM_TO_MAX   = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_vld,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_is_br,
    input  logic             ex_vld,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_is_load,
    input  logic             mem_vld,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             wb_vld,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             id_ex_flush,
    output logic             br_stall,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt
);

    // FSM encoding
    localparam logic [1:0] c_st_run      = 2'd0;
    localparam logic [1:0] c_st_br_wait  = 2'd1;
    localparam logic [1:0] c_st_mem_wait = 2'd2;

    localparam logic [2:0] c_br_cyc  = 3'(BR_STALL_CYC);
    localparam logic [7:0] c_to_max  = 8'(MEM_TO_MAX);

    // A producer only matches a consumer when valid and not targeting x0
    function automatic logic f_match(input logic [RA_W-1:0] a,
                                     input logic [RA_W-1:0] b,
                                     input logic            vld);
        return vld && (a == b) && (b != '0);
    endfunction

    logic [1:0]       r_state;
    logic [1:0]       r_saved_state;
    logic [2:0]       r_br_cnt;
    logic [2:0]       r_saved_cnt;
    logic [7:0]       r_wait_cnt;
    logic             r_timeout;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [1:0]       w_state_nxt;
    logic [1:0]       w_saved_state_nxt;
    logic [2:0]       w_br_cnt_nxt;
    logic [2:0]       w_saved_cnt_nxt;
    logic [7:0]       w_wait_cnt_nxt;
    logic             w_to_set;

    logic             w_if_id_en;
    logic             w_id_ex_en;
    logic             w_ex_mem_en;
    logic             w_mem_wb_en;
    logic             w_flush;
    logic             w_br_stall;
    logic             w_any_stall;

    logic             w_load_use;
    logic             w_hazard;
    logic             w_mem_stall;
    logic [1:0]       w_fwd_a;
    logic [1:0]       w_fwd_b;

    assign w_load_use = id_vld && ex_vld && ex_is_load &&
                        ((id_use_rs1 && f_match(id_rs1, ex_rd, 1'b1)) ||
                         (id_use_rs2 && f_match(id_rs2, ex_rd, 1'b1)));

    // A request that is answered in the same cycle costs nothing
    assign w_mem_stall = mem_req && !mem_ack;

    generate
        if (FWD_EN != 0) begin : g_fwd
            // Forwarding covers all RAW cases except a load still in EX
            assign w_hazard = w_load_use;
            assign w_fwd_a  = f_match(ex_rs1, mem_rd, mem_vld) ? 2'b01 :
                              f_match(ex_rs1, wb_rd,  wb_vld)  ? 2'b10 : 2'b00;
            assign w_fwd_b  = f_match(ex_rs2, mem_rd, mem_vld) ? 2'b01 :
                              f_match(ex_rs2, wb_rd,  wb_vld)  ? 2'b10 : 2'b00;
        end else begin : g_no_fwd
            // Without bypass paths any in-flight producer blocks ID
            logic w_raw1;
            logic w_raw2;
            assign w_raw1 = id_use_rs1 && (f_match(id_rs1, ex_rd,  ex_vld)  ||
                                           f_match(id_rs1, mem_rd, mem_vld) ||
                                           f_match(id_rs1, wb_rd,  wb_vld));
            assign w_raw2 = id_use_rs2 && (f_match(id_rs2, ex_rd,  ex_vld)  ||
                                           f_match(id_rs2, mem_rd, mem_vld) ||
                                           f_match(id_rs2, wb_rd,  wb_vld));
            assign w_hazard = w_load_use || (id_vld && (w_raw1 || w_raw2));
            assign w_fwd_a  = 2'b00;
            assign w_fwd_b  = 2'b00;
        end
    endgenerate

    // Next-state and stage-control decode; memory stall outranks everything
    always_comb begin
        w_if_id_en        = 1'b1;
        w_id_ex_en        = 1'b1;
        w_ex_mem_en       = 1'b1;
        w_mem_wb_en       = 1'b1;
        w_flush           = 1'b0;
        w_br_stall        = 1'b0;
        w_state_nxt       = r_state;
        w_saved_state_nxt = r_saved_state;
        w_br_cnt_nxt      = r_br_cnt;
        w_saved_cnt_nxt   = r_saved_cnt;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_to_set          = 1'b0;

        case (r_state)
            c_st_run, c_st_br_wait: begin
                if (w_mem_stall) begin
                    // Freeze; the request cycle is the first wait cycle
                    w_if_id_en        = 1'b0;
                    w_id_ex_en        = 1'b0;
                    w_ex_mem_en       = 1'b0;
                    w_mem_wb_en       = 1'b0;
                    w_state_nxt       = c_st_mem_wait;
                    w_saved_state_nxt = r_state;
                    w_saved_cnt_nxt   = r_br_cnt;
                    w_wait_cnt_nxt    = 8'd1;
                    w_to_set          = (c_to_max == 8'd1);
                end else if (r_state == c_st_run) begin
                    if (w_hazard) begin
                        // Hold IF/ID and PC, inject a bubble into EX
                        w_if_id_en = 1'b0;
                        w_br_stall = 1'b1;
                        w_flush    = 1'b1;
                    end else if (id_vld && id_is_br) begin
                        w_state_nxt  = c_st_br_wait;
                        w_br_cnt_nxt = c_br_cyc;
                    end
                end else begin
                    // Branch shadow: fetch bubbles until resolution
                    w_br_stall = 1'b1;
                    if (r_br_cnt <= 3'd1) begin
                        w_state_nxt  = c_st_run;
                        w_br_cnt_nxt = 3'd0;
                    end else begin
                        w_br_cnt_nxt = r_br_cnt - 3'd1;
                    end
                end
            end
            c_st_mem_wait: begin
                if (mem_ack || (r_wait_cnt >= c_to_max)) begin
                    // Ack (or expired wait) releases the pipe this cycle
                    w_state_nxt    = r_saved_state;
                    w_br_cnt_nxt   = r_saved_cnt;
                    w_wait_cnt_nxt = 8'd0;
                end else begin
                    w_if_id_en     = 1'b0;
                    w_id_ex_en     = 1'b0;
                    w_ex_mem_en    = 1'b0;
                    w_mem_wb_en    = 1'b0;
                    w_wait_cnt_nxt = r_wait_cnt + 8'd1;
                    w_to_set       = ((r_wait_cnt + 8'd1) == c_to_max);
                end
            end
            default: begin
                w_state_nxt = c_st_run;
            end
        endcase
    end

    assign w_any_stall = !(w_if_id_en && w_id_ex_en && w_ex_mem_en && w_mem_wb_en)
                         || w_br_stall;

    // FSM state, branch/wait counters and saved context
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= c_st_run;
            r_saved_state <= c_st_run;
            r_br_cnt      <= 3'd0;
            r_saved_cnt   <= 3'd0;
            r_wait_cnt    <= 8'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_saved_state <= w_saved_state_nxt;
            r_br_cnt      <= w_br_cnt_nxt;
            r_saved_cnt   <= w_saved_cnt_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
        end
    end

    // Sticky timeout flag and saturating stalled-cycle counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_to_set) begin
                r_timeout <= 1'b1;
            end
            if (w_any_stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    // Reset forces every control output low without waiting for a clock
    assign if_id_en    = !rst && w_if_id_en;
    assign id_ex_en    = !rst && w_id_ex_en;
    assign ex_mem_en   = !rst && w_ex_mem_en;
    assign mem_wb_en   = !rst && w_mem_wb_en;
    assign id_ex_flush = !rst && w_flush;
    assign br_stall    = !rst && w_br_stall;
    assign fwd_a_sel   = rst ? 2'b00 : w_fwd_a;
    assign fwd_b_sel   = rst ? 2'b00 : w_fwd_b;
    assign mem_timeout = r_timeout;
    assign stall_cnt   = r_stall_cnt;

endmodule
`default_nettype wire
